// File: rtl/gx400_video_timing_seq_if.sv
// Pixel-enable, fine-scroll inputs and all timing outputs of the GX400 video timing sequencer.
interface gx400_video_timing_seq_if;
  logic       i_CEN6;
  logic [2:0] i_SCROLL_A_FINE;
  logic [2:0] i_SCROLL_B_FINE;
  logic [8:0] o_HCNT;
  logic [8:0] o_VCNT;
  logic       o_HBLANK;
  logic       o_HSYNC;
  logic       o_VBLANK;
  logic       o_VSYNC;
  logic       o_1H_n;
  logic       o_2HD_CLKD;
  logic       o_4HD_CLKD;
  logic       o_SHIFT_A1_CLKD;
  logic       o_SHIFT_A2_CLKD;
  logic       o_SHIFT_B_CLKD;
  logic       o_LINE_START;

  modport master (
    output i_CEN6, i_SCROLL_A_FINE, i_SCROLL_B_FINE,
    input  o_HCNT, o_VCNT, o_HBLANK, o_HSYNC, o_VBLANK, o_VSYNC, o_1H_n,
           o_2HD_CLKD, o_4HD_CLKD, o_SHIFT_A1_CLKD, o_SHIFT_A2_CLKD,
           o_SHIFT_B_CLKD, o_LINE_START
  );

  modport slave (
    input  i_CEN6, i_SCROLL_A_FINE, i_SCROLL_B_FINE,
    output o_HCNT, o_VCNT, o_HBLANK, o_HSYNC, o_VBLANK, o_VSYNC, o_1H_n,
           o_2HD_CLKD, o_4HD_CLKD, o_SHIFT_A1_CLKD, o_SHIFT_A2_CLKD,
           o_SHIFT_B_CLKD, o_LINE_START
  );
endinterface

// File: rtl/gx400_video_timing_seq.sv
// GX400 video timing: pixel/line counters, registered blank/sync levels and
// tile/fine-scroll latch strobes gated by the 6 MHz pixel enable.
module gx400_video_timing_seq #(
  parameter int unsigned H_TOTAL = 384,
  parameter int unsigned V_TOTAL = 264
) (
  input  logic                      i_CLK,
  input  logic                      i_RST_n,
  gx400_video_timing_seq_if.slave   bus
);

  localparam int unsigned CNT_W = 9;
  localparam logic [CNT_W-1:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = 9'(V_TOTAL - 1);

  logic [CNT_W-1:0] hc;
  logic [CNT_W-1:0] vc;
  logic [CNT_W-1:0] hc_nxt;
  logic [CNT_W-1:0] vc_nxt;
  logic             hc_wrap;
  logic [2:0]       fine_a_q;
  logic [2:0]       fine_b_q;
  logic             hblank_q;
  logic             hsync_q;
  logic             vblank_q;
  logic             vsync_q;
  logic             h1_n_q;
  logic [2:0]       pa;
  logic [2:0]       pb;
  logic             stb_en;

  // Next-count values; levels are decoded from these so they line up with the counters.
  always_comb begin
    hc_wrap = (hc == H_LAST);
    hc_nxt  = hc_wrap ? '0 : hc + 9'd1;
    vc_nxt  = vc;
    if (hc_wrap) begin
      vc_nxt = (vc == V_LAST) ? '0 : vc + 9'd1;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      hc       <= '0;
      vc       <= '0;
      fine_a_q <= '0;
      fine_b_q <= '0;
      hblank_q <= 1'b0;
      hsync_q  <= 1'b0;
      vblank_q <= 1'b1;
      vsync_q  <= 1'b0;
      h1_n_q   <= 1'b1;
    end else if (bus.i_CEN6) begin
      hc       <= hc_nxt;
      vc       <= vc_nxt;
      hblank_q <= (hc_nxt >= 9'd256) && (hc_nxt <= 9'd383);
      hsync_q  <= (hc_nxt >= 9'd296) && (hc_nxt <= 9'd327);
      vblank_q <= (vc_nxt < 9'd16) || (vc_nxt > 9'd239);
      vsync_q  <= (vc_nxt >= 9'd248) && (vc_nxt <= 9'd255);
      h1_n_q   <= ~hc_nxt[0];
      // Fine scroll is captured at end of line so mid-line writes land on the next line.
      if (hc_wrap) begin
        fine_a_q <= bus.i_SCROLL_A_FINE;
        fine_b_q <= bus.i_SCROLL_B_FINE;
      end
    end
  end

  assign pa = hc[2:0] + fine_a_q;
  assign pb = hc[2:0] + fine_b_q;

  // Strobes are one enable wide and forced low while reset is held.
  assign stb_en = bus.i_CEN6 & i_RST_n;

  assign bus.o_HCNT          = hc;
  assign bus.o_VCNT          = vc;
  assign bus.o_HBLANK        = hblank_q;
  assign bus.o_HSYNC         = hsync_q;
  assign bus.o_VBLANK        = vblank_q;
  assign bus.o_VSYNC         = vsync_q;
  assign bus.o_1H_n          = h1_n_q;
  assign bus.o_4HD_CLKD      = stb_en & (hc[2:0] == 3'd3);
  assign bus.o_2HD_CLKD      = stb_en & (hc[2:0] == 3'd7);
  assign bus.o_SHIFT_A1_CLKD = stb_en & (pa == 3'd7);
  assign bus.o_SHIFT_A2_CLKD = stb_en & (pa == 3'd0);
  assign bus.o_SHIFT_B_CLKD  = stb_en & (pb == 3'd7);
  assign bus.o_LINE_START    = stb_en & (hc == '0);

endmodule
